// File: rtl/boot_pkg.sv
// Shared types and frame constants for the instruction-memory boot loader.
package boot_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LEN0,
    LEN1,
    DATA,
    CSUM,
    DONE,
    ERR
  } boot_state_e;

  localparam logic [7:0] DEF_SYNC_BYTE  = 8'hA5;
  localparam int         BYTE_W         = 8;
  localparam int         WORD_W         = 32;
  localparam int         LEN_W          = 16;  // LEN_LO + LEN_HI
  localparam int         IDX_W          = 11;  // holds 0..1024
  localparam int         BYTES_PER_WORD = 4;

endpackage

// File: rtl/boot_byte_packer.sv
// Packs a little-endian byte stream into 32-bit words; flags each completed word.
module boot_byte_packer
  import boot_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr_i,        // realign to lane 0
  input  logic              byte_vld_i,
  input  logic [BYTE_W-1:0] byte_i,
  output logic              word_done_o,  // combinational: this byte completes a word
  output logic              word_valid_o, // registered one-cycle pulse after completion
  output logic [WORD_W-1:0] word_o        // holds last completed word
);

  logic [1:0]          lane_q;
  logic [3*BYTE_W-1:0] sreg_q;
  logic [WORD_W-1:0]   word_q;
  logic                vld_q;

  assign word_done_o  = byte_vld_i && (lane_q == 2'd3);
  assign word_valid_o = vld_q;
  assign word_o       = word_q;

  // Lane counter and partial-word shift register; first byte ends up in the low lane.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lane_q <= '0;
      sreg_q <= '0;
    end else if (clr_i) begin
      lane_q <= '0;
    end else if (byte_vld_i) begin
      lane_q <= lane_q + 2'd1;
      sreg_q <= {byte_i, sreg_q[3*BYTE_W-1:BYTE_W]};
    end
  end

  // Capture the finished word so it stays stable until the next one completes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q  <= 1'b0;
      word_q <= '0;
    end else begin
      vld_q <= word_done_o;
      if (word_done_o) word_q <= {byte_i, sreg_q};
    end
  end

endmodule

// File: rtl/imem_boot_loader.sv
// Framed byte-stream boot loader: parses SYNC/LEN/DATA/CSUM, writes words to
// instruction memory and releases the core reset once the checksum matches.
module imem_boot_loader
  import boot_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          MAX_WORDS = 1024,
  parameter logic [7:0]  SYNC_BYTE = DEF_SYNC_BYTE
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  s_data,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic        restart,
  output logic        imem_we,
  output logic [31:0] imem_addr,
  output logic [31:0] imem_data,
  output logic        cpu_rst_n,
  output logic        boot_done,
  output logic        boot_err
);

  boot_state_e       state_q, state_d;
  logic [LEN_W-1:0]  len_q;
  logic [IDX_W-1:0]  idx_q;
  logic [BYTE_W-1:0] xor_q;
  logic [31:0]       addr_q;
  logic              rdy_q, rdy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              cpu_rst_q, cpu_rst_d;

  logic              acc;
  logic [LEN_W-1:0]  len_full;
  logic              last_word;
  logic              word_done;
  logic              word_valid;
  logic [WORD_W-1:0] word;

  assign acc       = s_valid && rdy_q;
  assign len_full  = {s_data, len_q[7:0]};
  assign last_word = (LEN_W'(idx_q) + LEN_W'(1)) == len_q;

  boot_byte_packer u_packer (
    .clk          (clk),
    .rst_n        (rst_n),
    .clr_i        (state_q != DATA),
    .byte_vld_i   (acc && (state_q == DATA)),
    .byte_i       (s_data),
    .word_done_o  (word_done),
    .word_valid_o (word_valid),
    .word_o       (word)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic; length is range-checked before DATA so idx_q never wraps.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (acc && (s_data == SYNC_BYTE)) state_d = LEN0;
      LEN0: if (acc) state_d = LEN1;
      LEN1: if (acc) begin
        if (len_full > LEN_W'(MAX_WORDS)) state_d = ERR;
        else if (len_full == '0)          state_d = CSUM;
        else                              state_d = DATA;
      end
      DATA: if (word_done && last_word) state_d = CSUM;
      CSUM: if (acc) state_d = (s_data == xor_q) ? DONE : ERR;
      DONE, ERR: if (restart) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output next-values, derived from the upcoming state so flags land with it.
  always_comb begin
    rdy_d     = !((state_d == DONE) || (state_d == ERR));
    done_d    = (state_d == DONE);
    err_d     = (state_d == ERR);
    cpu_rst_d = (state_d == DONE);
  end

  // Registered status outputs; s_ready stays low while in reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdy_q     <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      cpu_rst_q <= 1'b0;
    end else begin
      rdy_q     <= rdy_d;
      done_q    <= done_d;
      err_q     <= err_d;
      cpu_rst_q <= cpu_rst_d;
    end
  end

  // Length capture, word index and write address.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      len_q  <= '0;
      idx_q  <= '0;
      addr_q <= BASE_ADDR;
    end else begin
      if (acc && (state_q == LEN0)) len_q[7:0]  <= s_data;
      if (acc && (state_q == LEN1)) begin
        len_q[15:8] <= s_data;
        idx_q       <= '0;
      end
      if (word_done) begin
        idx_q  <= idx_q + IDX_W'(1);
        addr_q <= BASE_ADDR + 32'({idx_q, 2'b00});
      end
    end
  end

  // Running XOR over LEN_LO, LEN_HI and data; cleared at SYNC and on restart.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      xor_q <= '0;
    end else begin
      unique case (state_q)
        IDLE:             if (acc && (s_data == SYNC_BYTE)) xor_q <= '0;
        LEN0, LEN1, DATA: if (acc) xor_q <= xor_q ^ s_data;
        DONE, ERR:        if (restart) xor_q <= '0;
        default:          xor_q <= xor_q;
      endcase
    end
  end

  assign s_ready   = rdy_q;
  assign imem_we   = word_valid;
  assign imem_addr = addr_q;
  assign imem_data = word;
  assign cpu_rst_n = cpu_rst_q;
  assign boot_done = done_q;
  assign boot_err  = err_q;

endmodule

// File: tb/tb_imem_boot_loader.sv
// Directed bench for imem_boot_loader with a write scoreboard.
module tb_imem_boot_loader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  s_data;
  logic        s_valid;
  logic        s_ready;
  logic        restart;
  logic        imem_we;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic        cpu_rst_n;
  logic        boot_done;
  logic        boot_err;

  int checks = 0;
  int errors = 0;
  int wr_cnt = 0;

  logic [63:0] exp_q[$];   // {addr, data}
  logic [31:0] words[$];

  imem_boot_loader dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .s_data    (s_data),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .restart   (restart),
    .imem_we   (imem_we),
    .imem_addr (imem_addr),
    .imem_data (imem_data),
    .cpu_rst_n (cpu_rst_n),
    .boot_done (boot_done),
    .boot_err  (boot_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every write pops the oldest expectation.
  always @(negedge clk) begin
    if (imem_we === 1'b1) begin
      logic [63:0] e;
      wr_cnt++;
      checks++;
      assert (exp_q.size() != 0) else begin
        errors++;
        $error("FAIL unexpected_write: observed addr %h data %h expected none", imem_addr, imem_data);
      end
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("wr_addr", imem_addr, e[63:32]);
        chk("wr_data", imem_data, e[31:0]);
      end
      chk("wr_cpu_held", {31'd0, cpu_rst_n}, 32'd0);
    end
  end

  task automatic send_byte(input logic [7:0] b, input int maxgap);
    int t;
    int g;
    g = (maxgap > 0) ? $urandom_range(0, maxgap) : 0;
    repeat (g) @(negedge clk);
    @(negedge clk);
    s_data  = b;
    s_valid = 1'b1;
    t = 0;
    while (s_ready !== 1'b1 && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (t >= 100) begin
      checks++;
      errors++;
      $error("FAIL ready_timeout: observed s_ready %b expected 1", s_ready);
    end
    @(posedge clk);
    #1 s_valid = 1'b0;
  endtask

  // Sends a full frame built from 'words'; expectations pushed as bytes go out.
  task automatic send_frame(input int maxgap, input bit corrupt);
    logic [15:0] len;
    logic [7:0]  cs;
    logic [31:0] w;
    len = 16'(words.size());
    cs  = len[7:0] ^ len[15:8];
    send_byte(8'hA5, maxgap);
    send_byte(len[7:0], maxgap);
    send_byte(len[15:8], maxgap);
    for (int i = 0; i < words.size(); i++) begin
      w = words[i];
      exp_q.push_back({32'(i * 4), w});
      for (int k = 0; k < 4; k++) begin
        cs = cs ^ w[8*k +: 8];
        send_byte(w[8*k +: 8], maxgap);
      end
    end
    send_byte(corrupt ? (cs ^ 8'h01) : cs, maxgap);
  endtask

  task automatic do_restart();
    @(negedge clk);
    restart = 1'b1;
    @(negedge clk);
    restart = 1'b0;
    chk("rs_done", {31'd0, boot_done}, 32'd0);
    chk("rs_err", {31'd0, boot_err}, 32'd0);
    chk("rs_cpu", {31'd0, cpu_rst_n}, 32'd0);
    chk("rs_ready", {31'd0, s_ready}, 32'd1);
  endtask

  task automatic chk_done(input string tag, input int exp_writes);
    chk({tag, "_done"}, {31'd0, boot_done}, 32'd1);
    chk({tag, "_cpu"}, {31'd0, cpu_rst_n}, 32'd1);
    chk({tag, "_err"}, {31'd0, boot_err}, 32'd0);
    chk({tag, "_ready"}, {31'd0, s_ready}, 32'd0);
    chk({tag, "_pending"}, 32'(exp_q.size()), 32'd0);
    chk({tag, "_writes"}, 32'(wr_cnt), 32'(exp_writes));
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_ready"}, {31'd0, s_ready}, 32'd0);
    chk({tag, "_we"}, {31'd0, imem_we}, 32'd0);
    chk({tag, "_addr"}, imem_addr, 32'd0);
    chk({tag, "_data"}, imem_data, 32'd0);
    chk({tag, "_cpu"}, {31'd0, cpu_rst_n}, 32'd0);
    chk({tag, "_done"}, {31'd0, boot_done}, 32'd0);
    chk({tag, "_err"}, {31'd0, boot_err}, 32'd0);
  endtask

  initial begin
    int base;
    rst_n   = 1'b0;
    s_data  = 8'h00;
    s_valid = 1'b0;
    restart = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    chk_reset_vals("rst");
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rel_ready", {31'd0, s_ready}, 32'd1);
    chk("rel_cpu", {31'd0, cpu_rst_n}, 32'd0);

    // Single word: A5 01 00 13 00 00 00 12
    words = '{32'h0000_0013};
    send_frame(0, 1'b0);
    chk_done("one", 1);

    // Garbage then three words with gaps
    do_restart();
    send_byte(8'h00, 2);
    send_byte(8'hFF, 2);
    words = '{32'hDEAD_BEEF, 32'h0123_4567, 32'h89AB_CDEF};
    send_frame(3, 1'b0);
    chk_done("three", 4);

    // Bad checksum, then recover
    do_restart();
    words = '{32'h0000_0013};
    send_frame(0, 1'b1);
    chk("bad_err", {31'd0, boot_err}, 32'd1);
    chk("bad_cpu", {31'd0, cpu_rst_n}, 32'd0);
    chk("bad_ready", {31'd0, s_ready}, 32'd0);
    chk("bad_done", {31'd0, boot_done}, 32'd0);
    do_restart();
    send_frame(1, 1'b0);
    chk_done("recov", 6);

    // Length over limit
    do_restart();
    send_byte(8'hA5, 0);
    send_byte(8'h01, 0);
    send_byte(8'h04, 0);
    repeat (3) @(negedge clk);
    chk("big_err", {31'd0, boot_err}, 32'd1);
    chk("big_ready", {31'd0, s_ready}, 32'd0);
    chk("big_writes", 32'(wr_cnt), 32'd6);

    // Zero length
    do_restart();
    words.delete();
    send_frame(0, 1'b0);
    chk_done("zero", 6);

    // Maximum length
    do_restart();
    words.delete();
    for (int i = 0; i < 1024; i++) words.push_back($urandom());
    send_frame(0, 1'b0);
    chk_done("max", 1030);
    chk("max_last_addr", imem_addr, 32'h0000_0FFC);
    chk("max_last_data", imem_data, words[1023]);

    // Mid-frame async reset after two data bytes
    do_restart();
    send_byte(8'hA5, 0);
    send_byte(8'h01, 0);
    send_byte(8'h00, 0);
    send_byte(8'h13, 0);
    send_byte(8'h00, 0);
    #2 rst_n = 1'b0;
    #1;
    chk_reset_vals("mid");
    @(negedge clk);
    rst_n = 1'b1;
    base = wr_cnt;
    words = '{32'hCAFE_F00D, 32'h0000_0042};
    send_frame(2, 1'b0);
    chk_done("post", base + 2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global watchdog
  initial begin
    #2000000;
    $error("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
